idct4_ctrl: RTL and testbench

Sequencer for the HEVC 4x4 inverse transform. It accepts a 4x4 coefficient block over a valid/ready stream and stores it locally. It then time-shares one multiply-accumulate lane across a column pass (round 64, shift 7) and a row pass (round 2048, shift 12). The 16 residuals are streamed out with backpressure. It sits between the coefficient unpacker and the reconstruction adder.

---
 rtl/idct4_pkg.sv | 26 ++
 rtl/idct4_mac.sv | 47 ++++
 rtl/idct4_ctrl.sv | 89 ++++++++
 tb/tb_idct4_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/idct4_pkg.sv
// idct4_pkg: shared state enum, width defaults and constant helpers for the 4x4 inverse transform.
package idct4_pkg;
    localparam int W_DEF      = 25;
    localparam int ACC_W_DEF  = 34;
    localparam int SHIFT1_DEF = 7;
    localparam int SHIFT2_DEF = 12;
    localparam int CLIP_MAX   = 32767;
    localparam int CLIP_MIN   = -32768;

    typedef enum logic [1:0] {LOAD, PASS1, PASS2} state_t;

    localparam logic signed [7:0] COEF_M [16] = '{
        8'sd64,  8'sd64,  8'sd64,  8'sd64,
        8'sd83,  8'sd36, -8'sd36, -8'sd83,
        8'sd64, -8'sd64, -8'sd64,  8'sd64,
        8'sd36, -8'sd83,  8'sd83, -8'sd36
    };

    function automatic logic signed [7:0] coef(input logic [1:0] k, input logic [1:0] n);
        return COEF_M[{k, n}];
    endfunction

    function automatic int round_c(input int shift);
        return 1 << (shift - 1);
    endfunction
endpackage

// File: rtl/idct4_mac.sv
// idct4_mac: single signed multiply-accumulate lane with pass-selected round/shift.
// Ports: clk, reset (async active-low), en (step), k (term index, 0 clears),
//        pass (0 column pass, 1 row pass), c (coefficient), opnd (operand),
//        res (rounded/shifted result of acc+c*opnd, meaningful on k==3).
// Build option: IDCT_CLIP_EN saturates res to [-32768, 32767].
module idct4_mac
    import idct4_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SHIFT1 = SHIFT1_DEF,
    parameter int SHIFT2 = SHIFT2_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          k,
    input  logic                pass,
    input  logic signed [7:0]   c,
    input  logic signed [W-1:0] opnd,
    output logic signed [W-1:0] res
);
    localparam logic signed [ACC_W-1:0] RND1 = ACC_W'(round_c(SHIFT1));
    localparam logic signed [ACC_W-1:0] RND2 = ACC_W'(round_c(SHIFT2));

    logic signed [ACC_W-1:0] acc, c_x, o_x, prod, sum, rnd, shifted;

    assign c_x     = ACC_W'(c);
    assign o_x     = ACC_W'(opnd);
    assign prod    = c_x * o_x;
    assign sum     = (k == 2'd0 ? '0 : acc) + prod;
    assign rnd     = sum + (pass ? RND2 : RND1);
    assign shifted = pass ? rnd >>> SHIFT2 : rnd >>> SHIFT1;

`ifdef IDCT_CLIP_EN
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(CLIP_MAX);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(CLIP_MIN);
    assign res = W'(shifted > MAXV ? MAXV : (shifted < MINV ? MINV : shifted));
`else
    assign res = W'(shifted);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc <= '0;
        else if (en) acc <= sum;
    end
endmodule

// File: rtl/idct4_ctrl.sv
// idct4_ctrl: sequencer for the HEVC 4x4 inverse transform (load, column pass, row pass, stream out).
// Ports: clk, reset (async active-low); in_data/in_valid/in_ready coefficient stream
//        (row-major X[r][c]); out_data/out_valid/out_ready residual stream (row-major);
//        busy high during either transform pass.
// Build option: IDCT_CLIP_EN enables 16-bit saturation of both pass results.
module idct4_ctrl
    import idct4_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SHIFT1 = SHIFT1_DEF,
    parameter int SHIFT2 = SHIFT2_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);
    state_t state, state_n;
    logic [1:0] j, n, k;
    logic drain, adv, hs, last_k, last_r, wr_out;
    logic signed [W-1:0] x   [16];
    logic signed [W-1:0] tmp [16];
    logic signed [W-1:0] opnd, mac_res;

    assign hs     = out_valid && out_ready;
    assign last_k = k == 2'd3;
    assign last_r = {j, n} == 4'hf;
    // Row pass freezes on a stalled output and after the final result until it drains.
    assign adv    = state == PASS1 || (state == PASS2 && !drain && !(out_valid && !out_ready));
    assign wr_out = state == PASS2 && adv && last_k;
    // Column pass walks X[k][j]; row pass walks tmp[i][k] with i held in j.
    assign opnd   = state == PASS2 ? tmp[{j, k}] : x[{k, j}];

    idct4_mac #(.W(W), .ACC_W(ACC_W), .SHIFT1(SHIFT1), .SHIFT2(SHIFT2)) u_mac (
        .clk  (clk),
        .reset(reset),
        .en   (adv),
        .k    (k),
        .pass (state == PASS2),
        .c    (coef(k, n)),
        .opnd (opnd),
        .res  (mac_res)
    );

    always_comb begin
        in_ready = state == LOAD;
        busy     = state != LOAD;
        state_n  = (state == LOAD && in_valid && last_r) ? PASS1 :
                   (state == PASS1 && last_k && last_r)  ? PASS2 :
                   (state == PASS2 && drain && hs)       ? LOAD  : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            j         <= '0;
            n         <= '0;
            k         <= '0;
            drain     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (state == LOAD && in_valid) {j, n} <= {j, n} + 4'd1;
            if (adv) begin
                k <= k + 2'd1;
                if (last_k) {j, n} <= {j, n} + 4'd1;
            end
            if (wr_out) begin
                out_data  <= mac_res;
                out_valid <= 1'b1;
            end else if (hs) out_valid <= 1'b0;
            if (wr_out && last_r) drain <= 1'b1;
            else if (hs) drain <= 1'b0;
        end
    end

    // Register files are fully rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) x[{j, n}] <= in_data;
        if (state == PASS1 && last_k) tmp[{n, j}] <= mac_res;
    end
endmodule

// File: tb/tb_idct4_ctrl.sv
// tb_idct4_ctrl: self-checking bench for idct4_ctrl (directed table, random blocks, reset mid-pass).
module tb_idct4_ctrl;
    logic clk, reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic signed [24:0] in_data, out_data;
    int n_chk = 0, n_fail = 0, cyc = 0;

    int mm [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83}, '{64, -64, -64, 64}, '{36, -83, 83, -36}};

    typedef struct {
        int x00; int col0; int e00; int etmp; int eall; bit has_all; int mode;
    } vec_t;
    vec_t tbl [5];

    idct4_ctrl dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int fit(input longint v);
        logic signed [24:0] t;
        longint s;
        s = v;
`ifdef IDCT_CLIP_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        t = 25'(s);
        return int'(t);
    endfunction

    // Reference: tmp = M^T * X column-wise, res = tmp * M row-wise, floor-rounded.
    task automatic model(input int x [16], output int r [16], output int t [16]);
        longint s;
        for (int jj = 0; jj < 4; jj++)
            for (int nn = 0; nn < 4; nn++) begin
                s = 0;
                for (int kk = 0; kk < 4; kk++) s += longint'(mm[kk][nn]) * x[4*kk+jj];
                t[4*nn+jj] = fit(fdiv(s + 64, 128));
            end
        for (int ii = 0; ii < 4; ii++)
            for (int nn = 0; nn < 4; nn++) begin
                s = 0;
                for (int kk = 0; kk < 4; kk++) s += longint'(mm[kk][nn]) * t[4*ii+kk];
                r[4*ii+nn] = fit(fdiv(s + 2048, 4096));
            end
    endtask

    task automatic send_block(input int x [16], output int acc_edge);
        int sent = 0, w = 0;
        acc_edge = 0;
        while (sent < 16 && w < 100) begin
            in_data = 25'(x[sent]);
            in_valid = 1;
            @(negedge clk);
            if (in_ready) begin
                sent++;
                if (sent == 16) acc_edge = cyc + 1;
            end
            @(posedge clk); #1;
            w++;
        end
        in_valid = 0;
        chk("load_beats", sent, 16);
    endtask

    task automatic run_block(input int x [16], input int mode, input int stall, input int exp [16], output int got [16]);
        int acc_edge, ngot = 0, budget = 0, seen = 0, first = -1, last = -1;
        bit stalled = 0;
        for (int i = 0; i < 16; i++) got[i] = 0;
        send_block(x, acc_edge);
        while (ngot < 16 && budget < 3000) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (seen >= stall) : ($urandom_range(0, 2) != 0);
            in_valid = (mode == 2 && ngot < 15);
            in_data = 25'($urandom);
            @(negedge clk);
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk($sformatf("hold_data[%0d]", ngot), out_data, exp[ngot]);
            end
            if (out_valid) begin
                if (first < 0) first = cyc - acc_edge;
                if (mode == 1 && !out_ready) seen++;
                if (out_ready) begin
                    got[ngot] = out_data;
                    if (ngot == 15) last = cyc - acc_edge;
                    ngot++;
                end
            end
            stalled = out_valid && !out_ready;
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 0;
        chk("n_outputs", ngot, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("res[%0d]", i), got[i], exp[i]);
        if (mode == 0) begin
            chk("first_valid_latency", first, 68);
            chk("last_valid_latency", last, 128);
        end
        @(negedge clk);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_out_valid", out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int x [16], ex [16], t [16], got [16], ae;
        logic signed [15:0] r16;
        tbl[0] = '{0, 0, 0, 0, 0, 1'b1, 0};
        tbl[1] = '{64, 0, 1, 32, 1, 1'b1, 0};
        tbl[2] = '{-64, 0, 0, -32, 0, 1'b1, 0};
`ifdef IDCT_CLIP_EN
        tbl[3] = '{32767, 32767, 512, 32767, 0, 1'b0, 0};
`else
        tbl[3] = '{32767, 32767, 988, 63230, 0, 1'b0, 0};
`endif
        tbl[4] = '{64, 0, 1, 32, 1, 1'b1, 1};
        reset = 0; in_valid = 0; in_data = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 16; i++) x[i] = 0;
            x[0] = tbl[v].x00;
            for (int kk = 1; kk < 4; kk++) x[4*kk] = tbl[v].col0;
            model(x, ex, t);
            run_block(x, tbl[v].mode, 10, ex, got);
            chk($sformatf("v%0d_res00", v), got[0], tbl[v].e00);
            chk($sformatf("v%0d_tmp00", v), dut.tmp[0], tbl[v].etmp);
            for (int i = 0; i < 16; i++) chk($sformatf("v%0d_tmp[%0d]", v, i), dut.tmp[i], t[i]);
            if (tbl[v].has_all)
                for (int i = 0; i < 16; i++) chk($sformatf("v%0d_all[%0d]", v, i), got[i], tbl[v].eall);
        end

        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 16; i++) begin
                r16 = 16'($urandom);
                x[i] = (b == 0) ? -32768 : (b == 1) ? 32767 : int'(r16);
            end
            model(x, ex, t);
            run_block(x, (b < 2) ? 0 : 2, 0, ex, got);
        end

        for (int i = 0; i < 16; i++) x[i] = 0;
        x[0] = 64;
        send_block(x, ae);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        reset = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        model(x, ex, t);
        run_block(x, 0, 0, ex, got);
        for (int i = 0; i < 16; i++) chk($sformatf("after_rst[%0d]", i), got[i], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
